// File: rtl/rank_store_arbiter_pkg.sv
// rtl/rank_store_arbiter_pkg.sv - shared constants and types for the rank-store arbiter
//
// Contents:
//   NREQ_DEF / WIDTH_DEF / ADDWIDTH_DEF : default requester count, word width, address width
//   IDW_DEF                             : requester index width for the default configuration
//   VALID_BIT                           : position of the entry-valid flag inside a data word
//   DROP_W                              : width of the dropped-write counter
//   req_id_t                            : requester index type (default configuration)
package pagerank_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int WIDTH_DEF    = 32;
    localparam int ADDWIDTH_DEF = 6;
    localparam int IDW_DEF      = $clog2(NREQ_DEF);

    // Words whose valid flag is clear are never stored by the file.
    localparam int VALID_BIT    = 0;

    localparam int DROP_W       = 16;

    typedef logic [IDW_DEF-1:0] req_id_t;

endpackage

// File: rtl/rank_store_arbiter_rr_arbiter.sv
// rtl/rank_store_arbiter_rr_arbiter.sv - round-robin arbiter with its own priority pointer
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset (pointer returns to 0)
//   req_i     in   [N]  request vector
//   advance_i in   allow the pointer to move past the granted index this cycle
//   gnt_o     out  [N]  one-hot grant (combinational, zero when no request)
//   index_o   out  [IW] index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;

    // One extra bit so ptr + k (at most 2N-2) never overflows before the wrap.
    logic [IW:0]   cand;

    // Scan from the pointer upward, wrapping mod N; the first requester wins.
    always_comb begin
        gnt_o   = '0;
        index_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt_o[cand[IW-1:0]]  = 1'b1;
                index_o              = cand[IW-1:0];
            end
        end
    end

    // The winner drops to lowest priority; an idle cycle leaves the pointer alone.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (index_o == IW'(N - 1)) ? '0 : index_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rank_store_arbiter.sv
// rtl/rank_store_arbiter.sv - shares one rank-store register file between NREQ requesters
//
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   rd_req/rd_addr    per-requester read request and flattened read addresses
//   rd_gnt            one-hot combinational read grant
//   rsp_valid/rsp_data one-hot response strobe and data, one cycle after the read grant
//   wr_req/wr_addr/wr_data per-requester write request, flattened addresses and data
//   wr_gnt            one-hot combinational write grant
//   drop_cnt          saturating count of granted writes whose valid flag was clear
//   rf_readEnable/rf_source                  register file read port
//   rf_writeEnable/rf_dest/rf_dataIn         register file write port
//   rf_dataOut        registered read data from the file
module rank_store_arbiter
    import pagerank_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDWIDTH = ADDWIDTH_DEF,
    parameter int IDW      = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          rd_req,
    input  logic [NREQ*ADDWIDTH-1:0] rd_addr,
    output logic [NREQ-1:0]          rd_gnt,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    input  logic [NREQ-1:0]          wr_req,
    input  logic [NREQ*ADDWIDTH-1:0] wr_addr,
    input  logic [NREQ*WIDTH-1:0]    wr_data,
    output logic [NREQ-1:0]          wr_gnt,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic                     rf_readEnable,
    output logic [ADDWIDTH-1:0]      rf_source,
    output logic                     rf_writeEnable,
    output logic [ADDWIDTH-1:0]      rf_dest,
    output logic [WIDTH-1:0]         rf_dataIn,
    input  logic [WIDTH-1:0]         rf_dataOut
);

    logic [ADDWIDTH-1:0] rd_addr_a [NREQ];
    logic [ADDWIDTH-1:0] wr_addr_a [NREQ];
    logic [WIDTH-1:0]    wr_data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rd_addr_a[i] = rd_addr[i*ADDWIDTH +: ADDWIDTH];
        assign wr_addr_a[i] = wr_addr[i*ADDWIDTH +: ADDWIDTH];
        assign wr_data_a[i] = wr_data[i*WIDTH +: WIDTH];
    end

    // Requests are masked while reset is held so no grant (and hence no
    // register file access) can leak out during reset.
    logic [NREQ-1:0] rd_req_m;
    logic [NREQ-1:0] wr_req_m;
    logic [IDW-1:0]  rd_idx;
    logic [IDW-1:0]  wr_idx;
    logic            rd_any;
    logic            wr_any;

    assign rd_req_m = rd_req & {NREQ{reset}};
    assign wr_req_m = wr_req & {NREQ{reset}};

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_rd_arb (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (rd_req_m),
        .advance_i (reset),
        .gnt_o     (rd_gnt),
        .index_o   (rd_idx)
    );

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_wr_arb (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (wr_req_m),
        .advance_i (reset),
        .gnt_o     (wr_gnt),
        .index_o   (wr_idx)
    );

    assign rd_any = |rd_gnt;
    assign wr_any = |wr_gnt;

    // Register file ports are driven only by the granted requester, else zero.
    always_comb begin
        rf_readEnable  = rd_any;
        rf_source      = '0;
        rf_writeEnable = wr_any;
        rf_dest        = '0;
        rf_dataIn      = '0;
        if (rd_any) begin
            rf_source = rd_addr_a[rd_idx];
        end
        if (wr_any) begin
            rf_dest   = wr_addr_a[wr_idx];
            rf_dataIn = wr_data_a[wr_idx];
        end
    end

    // Response tag, write-to-read bypass and drop counter state.
    logic                 tag_valid_q, tag_valid_d;
    logic [IDW-1:0]       tag_id_q,    tag_id_d;
    logic                 byp_valid_q, byp_valid_d;
    logic [WIDTH-1:0]     byp_data_q,  byp_data_d;
    logic [DROP_W-1:0]    drop_cnt_q,  drop_cnt_d;

    always_comb begin
        tag_valid_d = rd_any;
        tag_id_d    = rd_idx;
        // The file returns the pre-write word on a same-address collision, so
        // the write data is carried alongside the tag. A word with its valid
        // flag clear is never stored, so it must not be forwarded either.
        byp_valid_d = rd_any && wr_any && (rf_source == rf_dest)
                      && rf_dataIn[VALID_BIT];
        byp_data_d  = rf_dataIn;

        drop_cnt_d  = drop_cnt_q;
        if (wr_any && !rf_dataIn[VALID_BIT] && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= 1'b0;
            tag_id_q    <= '0;
            byp_valid_q <= 1'b0;
            byp_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_id_q    <= tag_id_d;
            byp_valid_q <= byp_valid_d;
            byp_data_q  <= byp_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_valid_q) begin
            rsp_valid = NREQ'(1) << tag_id_q;
            rsp_data  = byp_valid_q ? byp_data_q : rf_dataOut;
        end
    end

    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rank_store_arbiter.sv
// tb/tb_rank_store_arbiter.sv - self-checking bench for rank_store_arbiter
module tb_rank_store_arbiter;
    import pagerank_pkg::*;

    localparam int N = NREQ_DEF;
    localparam int W = WIDTH_DEF;
    localparam int A = ADDWIDTH_DEF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   rd_req, wr_req;
    logic [A-1:0]   t_rd_addr [N];
    logic [A-1:0]   t_wr_addr [N];
    logic [W-1:0]   t_wr_data [N];
    logic [N*A-1:0] rd_addr, wr_addr;
    logic [N*W-1:0] wr_data;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign rd_addr[i*A +: A] = t_rd_addr[i];
        assign wr_addr[i*A +: A] = t_wr_addr[i];
        assign wr_data[i*W +: W] = t_wr_data[i];
    end

    logic [N-1:0]  rd_gnt, wr_gnt, rsp_valid;
    logic [W-1:0]  rsp_data, rf_dataIn;
    logic [W-1:0]  rf_dataOut = '0;
    logic [15:0]   drop_cnt;
    logic          rf_readEnable, rf_writeEnable;
    logic [A-1:0]  rf_source, rf_dest;

    rank_store_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .wr_req         (wr_req),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_gnt         (wr_gnt),
        .drop_cnt       (drop_cnt),
        .rf_readEnable  (rf_readEnable),
        .rf_source      (rf_source),
        .rf_writeEnable (rf_writeEnable),
        .rf_dest        (rf_dest),
        .rf_dataIn      (rf_dataIn),
        .rf_dataOut     (rf_dataOut)
    );

    // Register file: registered read (old contents), stores only valid words.
    logic [W-1:0] mem [2**A];
    always @(posedge clk) begin
        if (rf_readEnable) rf_dataOut <= mem[rf_source];
        if (rf_writeEnable && rf_dataIn[VALID_BIT]) mem[rf_dest] <= rf_dataIn;
    end

    // Reference model state.
    logic [W-1:0] gold [2**A];
    int           m_rptr, m_wptr, m_drop;
    bit           pend_valid;
    int           pend_id;
    logic [W-1:0] pend_data;
    int           last_r, last_w;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        int           r, w;
        logic [N-1:0] eg_r, eg_w, e_rv;
        logic [A-1:0] e_src, e_dst;
        logic [W-1:0] e_din, e_rd, nd;
        bit           nv;
        int           nid;
        @(negedge clk);
        if (!reset) begin
            m_rptr = 0; m_wptr = 0; m_drop = 0; pend_valid = 0;
            r = -1; w = -1;
        end else begin
            r = pick(rd_req, m_rptr);
            w = pick(wr_req, m_wptr);
        end
        eg_r = '0; eg_w = '0; e_src = '0; e_dst = '0; e_din = '0;
        if (r >= 0) begin eg_r[r] = 1'b1; e_src = t_rd_addr[r]; end
        if (w >= 0) begin eg_w[w] = 1'b1; e_dst = t_wr_addr[w]; e_din = t_wr_data[w]; end
        e_rv = '0; e_rd = '0;
        if (pend_valid) begin e_rv[pend_id] = 1'b1; e_rd = pend_data; end

        check("rd_gnt",    64'(rd_gnt),         64'(eg_r));
        check("wr_gnt",    64'(wr_gnt),         64'(eg_w));
        check("rf_re",     64'(rf_readEnable),  64'(r >= 0));
        check("rf_src",    64'(rf_source),      64'(e_src));
        check("rf_we",     64'(rf_writeEnable), 64'(w >= 0));
        check("rf_dst",    64'(rf_dest),        64'(e_dst));
        check("rf_din",    64'(rf_dataIn),      64'(e_din));
        check("rsp_valid", 64'(rsp_valid),      64'(e_rv));
        check("rsp_data",  64'(rsp_data),       64'(e_rd));
        check("drop_cnt",  64'(drop_cnt),       64'(m_drop));

        nv = 0; nid = 0; nd = '0;
        if (r >= 0) begin
            nv = 1; nid = r;
            nd = gold[t_rd_addr[r]];
            if (w >= 0 && t_wr_addr[w] == t_rd_addr[r] && t_wr_data[w][VALID_BIT])
                nd = t_wr_data[w];
            m_rptr = (r + 1) % N;
        end
        if (w >= 0) begin
            if (t_wr_data[w][VALID_BIT]) gold[t_wr_addr[w]] = t_wr_data[w];
            else if (m_drop < 65535) m_drop++;
            m_wptr = (w + 1) % N;
        end
        pend_valid = nv; pend_id = nid; pend_data = nd;
        last_r = r; last_w = w;
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] seq [5];

    initial begin
        for (int i = 0; i < 2**A; i++) begin
            mem[i]  = $urandom;
            gold[i] = mem[i];
        end
        mem[5] = 32'h0000_00A3; gold[5] = 32'h0000_00A3;
        mem[7] = 32'h0000_0011; gold[7] = 32'h0000_0011;
        rd_req = '0; wr_req = '0;
        for (int i = 0; i < N; i++) begin
            t_rd_addr[i] = '0; t_wr_addr[i] = '0; t_wr_data[i] = '0;
        end
        m_rptr = 0; m_wptr = 0; m_drop = 0; pend_valid = 0; pend_id = 0; pend_data = '0;
        last_r = -1; last_w = -1;

        // Reset held, requests present: everything must stay quiet.
        rd_req = 4'b1111; wr_req = 4'b1111;
        step();
        step();
        rd_req = '0; wr_req = '0;
        reset = 1'b1;

        // Single read of address 5.
        rd_req = 4'b0001; t_rd_addr[0] = 6'd5;
        step();
        rd_req = '0;
        check("tp1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        check("tp1_rsp_data",  64'(rsp_data),  64'(32'hA3));

        // Same-cycle write and read of address 3: bypass.
        wr_req = 4'b0100; t_wr_addr[2] = 6'd3; t_wr_data[2] = 32'h55;
        rd_req = 4'b0010; t_rd_addr[1] = 6'd3;
        step();
        rd_req = '0; wr_req = '0;
        check("tp3_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        check("tp3_rsp_data",  64'(rsp_data),  64'(32'h55));
        rd_req = 4'b0001; t_rd_addr[0] = 6'd3;
        step();
        rd_req = '0;
        check("tp3_reread", 64'(rsp_data), 64'(32'h55));

        // Dropped write to address 7 with a colliding read.
        check("tp4_drop0", 64'(drop_cnt), 64'd0);
        wr_req = 4'b0001; t_wr_addr[0] = 6'd7; t_wr_data[0] = 32'h54;
        rd_req = 4'b1000; t_rd_addr[3] = 6'd7;
        step();
        rd_req = '0; wr_req = '0;
        check("tp4_drop1",     64'(drop_cnt),  64'd1);
        check("tp4_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
        check("tp4_rsp_data",  64'(rsp_data),  64'(32'h11));
        rd_req = 4'b0001; t_rd_addr[0] = 6'd7;
        step();
        rd_req = '0;
        check("tp4_reread", 64'(rsp_data), 64'(32'h11));

        // Reset asserted while a response is on the outputs.
        rd_req = 4'b0010; t_rd_addr[1] = 6'd5;
        step();
        reset = 1'b0;
        #1;
        check("tp5_rsp_cleared", 64'(rsp_valid), 64'd0);
        check("tp5_drop_cleared", 64'(drop_cnt), 64'd0);
        rd_req = 4'b1111;
        for (int i = 0; i < N; i++) t_rd_addr[i] = A'(i + 4);
        step();
        reset = 1'b1;
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("tp5_gnt_seq", 64'(rd_gnt), 64'(seq[k]));
            step();
            check("tp5_rsp_seq", 64'(rsp_valid), 64'(seq[k]));
        end
        rd_req = '0;

        // Randomised traffic: requests held until granted, narrow address range
        // to provoke collisions, one reset pulse mid-run.
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (last_r == i) rd_req[i] = 1'b0;
                if (last_w == i) wr_req[i] = 1'b0;
                if (!rd_req[i] && $urandom_range(0, 1) == 1) begin
                    rd_req[i] = 1'b1;
                    t_rd_addr[i] = A'($urandom_range(0, 7));
                end
                if (!wr_req[i] && $urandom_range(0, 2) == 0) begin
                    wr_req[i] = 1'b1;
                    t_wr_addr[i] = A'($urandom_range(0, 7));
                    t_wr_data[i] = $urandom;
                end
            end
            reset = (cyc != 200);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
